uart_tx_serializer: RTL and testbench

//  Byte-to-line UART transmitter that consumes the byte stream popped from the

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_tick.sv | 43 ++++
 rtl/uart_tx_serializer.sv | 155 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART shared definitions: transmitter FSM encoding, parity modes and the
// baud divisor helper (also intended for a future receiver).
// No ports; imported by uart_tx_serializer and uart_baud_tick.
package uart_pkg;

    // State names carry an ST_ prefix so they cannot collide with the
    // PARITY / STOP_BITS parameters of the modules that import this package.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Divisor rounded to the nearest integer so the bit period error stays
    // within half a clock.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable bit-period down-counter: tick_o marks the last cycle of each bit.
// Ports: clk_i/rst_ni clock and async reset; load_i restarts a bit period;
//   en_i runs the counter (cleared to 0 when low); tick_o high while count is 0.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned          CNT_W  = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]     RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Reloads happen only on load_i or at terminal count; never wraps freely.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q == '0) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: one byte per valid/ready handshake, sent LSB-first as
//   start + DATA_BITS + optional parity + 1/2 stop bits, CLKS_PER_BIT each.
// Ports: clk_i/rst_ni clock and async active-low reset; tx_data_i/tx_valid_i/
//   tx_ready_o byte handshake (ready only in IDLE, no queuing); tx_busy_o
//   frame in flight; tx_done_o pulse on last stop cycle; uart_tx_o line pin.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned BAUD_RATE   = 115_200,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = PAR_NONE,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_busy_o,
    output logic       tx_done_o,
    output logic       uart_tx_o
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam logic [7:0]  DATA_MASK    = 8'((1 << DATA_BITS) - 1);
    localparam logic [2:0]  LAST_DATA    = 3'(DATA_BITS - 1);
    localparam logic [2:0]  LAST_STOP    = 3'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_serializer: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx_serializer: DATA_BITS must be 5..8");
    end
    if (PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end

    uart_tx_state_e state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic           par_q, par_d;
    logic           line_q, line_d;
    logic           done;
    logic           tick;
    logic           load;
    logic [7:0]     data_masked;

    assign data_masked = tx_data_i & DATA_MASK;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        done      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (tx_valid_i) begin
                    state_d   = ST_START;
                    shift_d   = data_masked;
                    bit_cnt_d = '0;
                    // Parity taken from the byte as accepted, before shifting.
                    par_d     = (PARITY == PAR_ODD) ? ~^data_masked : ^data_masked;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d   = ST_STOP;
                    bit_cnt_d = '0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                        done      = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The pin value is decoded from next state and registered, so the line
    // changes exactly on the edge that enters each bit and never glitches.
    always_comb begin
        line_d = 1'b1;
        unique case (state_d)
            ST_START:  line_d = 1'b0;
            ST_DATA:   line_d = shift_d[0];
            ST_PARITY: line_d = par_d;
            default:   line_d = 1'b1;
        endcase
    end

    // Restart the bit period on every entry into a non-idle state.
    assign load = (state_d != state_q) && (state_d != ST_IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .load_i(load),
        .en_i  (state_q != ST_IDLE),
        .tick_o(tick)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            line_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            line_q    <= line_d;
        end
    end

    assign tx_ready_o = (state_q == ST_IDLE);
    assign tx_busy_o  = ~tx_ready_o;
    assign tx_done_o  = done;
    assign uart_tx_o  = line_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four instances (8N1, 8E1, 8O1, 8N2) at
// 10 clocks per bit, table-driven frames plus back-to-back and reset cases.
module tb_uart_tx_serializer;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic [3:0] valid;
    wire  [3:0] rdy, bsy, dn, line;
    logic [3:0] mon_en;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100), .DATA_BITS(8),
                         .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data), .tx_valid_i(valid[0]),
        .tx_ready_o(rdy[0]), .tx_busy_o(bsy[0]), .tx_done_o(dn[0]), .uart_tx_o(line[0]));
    uart_tx_serializer #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100), .DATA_BITS(8),
                         .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data), .tx_valid_i(valid[1]),
        .tx_ready_o(rdy[1]), .tx_busy_o(bsy[1]), .tx_done_o(dn[1]), .uart_tx_o(line[1]));
    uart_tx_serializer #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100), .DATA_BITS(8),
                         .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data), .tx_valid_i(valid[2]),
        .tx_ready_o(rdy[2]), .tx_busy_o(bsy[2]), .tx_done_o(dn[2]), .uart_tx_o(line[2]));
    uart_tx_serializer #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100), .DATA_BITS(8),
                         .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data), .tx_valid_i(valid[3]),
        .tx_ready_o(rdy[3]), .tx_busy_o(bsy[3]), .tx_done_o(dn[3]), .uart_tx_o(line[3]));

    typedef struct {
        int         k;
        logic [7:0] data;
        logic       par;
        int         done_cyc;
        int         rdy_cyc;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } exp_t;

    exp_t sb[4][$];
    int   frames[4];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic int par_of(input int k);
        case (k)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int stop_of(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int k, input logic [7:0] d, input logic p);
        exp_t e;
        e.data = d;
        e.par  = p;
        sb[k].push_back(e);
    endtask

    // Line decoder: samples every bit at its centre and scores against the queue.
    task automatic mon(input int k);
        forever begin
            @(negedge clk);
            if (mon_en[k] && rst_n && line[k] == 1'b0) begin
                logic [7:0] d;
                logic       p;
                logic       frm_ok;
                exp_t       e;
                d = '0;
                p = 1'b0;
                repeat (CPB / 2) @(negedge clk);
                frm_ok = (line[k] == 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    d[i] = line[k];
                end
                if (par_of(k) != 0) begin
                    repeat (CPB) @(negedge clk);
                    p = line[k];
                end
                for (int s = 0; s < stop_of(k); s++) begin
                    repeat (CPB) @(negedge clk);
                    frm_ok = frm_ok & line[k];
                end
                frames[k]++;
                if (sb[k].size() == 0) begin
                    check($sformatf("inst%0d unexpected frame data", k), 32'(d), -1);
                end else begin
                    e = sb[k].pop_front();
                    check($sformatf("inst%0d decoded data", k), 32'(d), 32'(e.data));
                    if (par_of(k) != 0)
                        check($sformatf("inst%0d decoded parity", k), 32'(p), 32'(e.par));
                    check($sformatf("inst%0d framing", k), 32'(frm_ok), 1);
                end
            end
        end
    endtask

    // Drive one byte (called on a negedge) and check the line cycle by cycle.
    task automatic apply(input string tag, input vec_t v);
        logic fb[12];
        int   nb, done_n, done_at, rdy_at, bad_at, busy1, expb;
        for (int i = 0; i < 12; i++) fb[i] = 1'b1;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[1 + i] = v.data[i];
        nb = 9;
        if (par_of(v.k) != 0) begin
            fb[nb] = v.par;
            nb++;
        end
        nb = nb + stop_of(v.k);
        check({tag, " ready before"}, 32'(rdy[v.k]), 1);
        tx_data     = v.data;
        valid[v.k]  = 1'b1;
        push_exp(v.k, v.data, v.par);
        @(posedge clk);
        #1 valid[v.k] = 1'b0;
        done_n = 0; done_at = 0; rdy_at = 0; bad_at = 0; busy1 = 0;
        for (int n = 1; n <= v.rdy_cyc + 20 && rdy_at == 0; n++) begin
            @(negedge clk);
            expb = (n <= nb * CPB) ? int'(fb[(n - 1) / CPB]) : 1;
            if (int'(line[v.k]) != expb && bad_at == 0) bad_at = n;
            if (dn[v.k]) begin
                done_n++;
                if (done_at == 0) done_at = n;
            end
            if (n == 1) busy1 = int'(bsy[v.k]);
            if (rdy[v.k]) rdy_at = n;
        end
        check({tag, " first bad line cycle"}, bad_at, 0);
        check({tag, " done cycle"}, done_at, v.done_cyc);
        check({tag, " done pulses"}, done_n, 1);
        check({tag, " ready cycle"}, rdy_at, v.rdy_cyc);
        check({tag, " busy after accept"}, busy1, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[11];
        vec_t vr;
        int   f0, rdy_at;

        vt[0]  = '{0, 8'h55, 1'b0, 100, 101};
        vt[1]  = '{0, 8'h00, 1'b0, 100, 101};
        vt[2]  = '{0, 8'h81, 1'b0, 100, 101};
        vt[3]  = '{1, 8'h07, 1'b1, 110, 111};
        vt[4]  = '{2, 8'h07, 1'b0, 110, 111};
        vt[5]  = '{1, 8'hA3, 1'b0, 110, 111};
        vt[6]  = '{2, 8'hA3, 1'b1, 110, 111};
        vt[7]  = '{3, 8'hA3, 1'b0, 110, 111};
        vt[8]  = '{1, 8'h00, 1'b0, 110, 111};
        vt[9]  = '{2, 8'h00, 1'b1, 110, 111};
        vt[10] = '{3, 8'h5A, 1'b0, 110, 111};

        rst_n   = 1'b0;
        valid   = '0;
        tx_data = '0;
        mon_en  = 4'hF;
        for (int k = 0; k < 4; k++) frames[k] = 0;
        fork
            mon(0);
            mon(1);
            mon(2);
            mon(3);
        join_none

        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("inst%0d reset line", k), 32'(line[k]), 1);
            check($sformatf("inst%0d reset ready", k), 32'(rdy[k]), 1);
            check($sformatf("inst%0d reset busy", k), 32'(bsy[k]), 0);
            check($sformatf("inst%0d reset done", k), 32'(dn[k]), 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++) apply($sformatf("vec%0d", i), vt[i]);

        // Valid held across two bytes: second start follows the single idle cycle.
        repeat (3) @(negedge clk);
        f0 = frames[0];
        tx_data  = 8'h3C;
        valid[0] = 1'b1;
        push_exp(0, 8'h3C, 1'b0);
        @(posedge clk);
        #1 tx_data = 8'hC3;
        push_exp(0, 8'hC3, 1'b0);
        rdy_at = 0;
        for (int n = 1; n <= 130 && rdy_at == 0; n++) begin
            @(negedge clk);
            if (rdy[0]) rdy_at = n;
        end
        check("b2b first ready cycle", rdy_at, 101);
        @(posedge clk);
        #1 valid[0] = 1'b0;
        @(negedge clk);
        check("b2b adjacent start bit", 32'(line[0]), 0);
        check("b2b busy on second", 32'(rdy[0]), 0);
        repeat (30) @(negedge clk);
        tx_data  = 8'h99;
        valid[0] = 1'b1;
        check("midframe ready low", 32'(rdy[0]), 0);
        @(negedge clk);
        valid[0] = 1'b0;
        rdy_at = 0;
        for (int n = 1; n <= 130 && rdy_at == 0; n++) begin
            @(negedge clk);
            if (rdy[0]) rdy_at = n;
        end
        check("b2b second frame ends", 32'(rdy_at != 0), 1);
        repeat (5) @(negedge clk);
        check("b2b frame count", frames[0] - f0, 2);
        check("b2b queue drained", sb[0].size(), 0);

        // Reset in the middle of a frame.
        mon_en[0] = 1'b0;
        tx_data   = 8'h12;
        valid[0]  = 1'b1;
        @(posedge clk);
        #1 valid[0] = 1'b0;
        repeat (35) @(negedge clk);
        check("rst line low before", 32'(line[0]), 0);
        #1 rst_n = 1'b0;
        #1;
        check("rst line high", 32'(line[0]), 1);
        check("rst ready", 32'(rdy[0]), 1);
        check("rst busy", 32'(bsy[0]), 0);
        check("rst no done", 32'(dn[0]), 0);
        repeat (2) @(negedge clk);
        check("rst held no done", 32'(dn[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst released line", 32'(line[0]), 1);
        mon_en[0] = 1'b1;
        vr = '{0, 8'hFF, 1'b0, 100, 101};
        apply("after reset 0xFF", vr);

        repeat (20) @(negedge clk);
        for (int k = 0; k < 4; k++)
            check($sformatf("inst%0d queue empty at end", k), sb[k].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
